dds_phase_osc: RTL
==================

Name: dds_phase_osc

Overview:
DDS oscillator that consumes the 32-bit phase-increment word (ADDER) produced by the note/pitch-to-DDS converter. It keeps a phase accumulator that advances once per sample strobe and slews the active increment toward the loaded target (portamento). It renders a signed 16-bit saw, square or triangle sample per tick for the voice mixer, and pulses a wrap flag on each phase cycle.

Parameters:
ACC_W, 32, phase accumulator and increment width
OUT_W, 16, signed output sample width; waveform taken from phase[ACC_W-1 -: OUT_W]

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
sample_en  in  1  one-cycle sample-rate strobe; back-to-back every cycle allowed
adder_in  in  32  phase increment (ADDER word from note_pitch2dds)
adder_ld  in  1  strobe: latch adder_in as target increment
glide_en  in  1  1 = slew current increment toward target; 0 = jump immediately
glide_rate  in  4  glide shift amount (larger = slower)
wave_sel  in  2  0 saw, 1 square, 2 triangle, 3 silence
hard_sync  in  1  phase reset request, sampled only with sample_en
out_wave  out  16  signed sample
out_valid  out  1  one-cycle pulse when out_wave updates
wrap  out  1  one-cycle pulse when phase wraps or is hard-synced

Behaviour:
- Reset (sync, active-high): phase, cur_inc, target_inc = 0; out_wave = 0, out_valid = 0, wrap = 0. Pipeline contents are discarded, so an in-flight out_valid never appears. rst has priority over all inputs.
- adder_ld: target_inc <= adder_in. If glide_en = 0, cur_inc <= adder_in on the same edge.
- Glide, on a sample_en cycle with glide_en = 1 and cur_inc != target_inc:
  - d = |target - cur| >> glide_rate; if d == 0 then d = 1.
  - cur moves toward target by d and never overshoots.
  - Arithmetic is unsigned 32-bit.
- Glide disable: if glide_en falls while cur != target, cur_inc <= target_inc on the next edge.
- Accumulator (stage 1), on sample_en:
  - hard_sync = 1: phase <= 0 and wrap <= 1.
  - Otherwise phase <= phase + cur_inc, mod 2^32, and wrap <= carry-out.
  - The increment used is the cur_inc value before any same-cycle adder_ld or glide update; the new increment applies from the next tick.
- wrap is high for exactly one cycle, in cycle n+1 after sample_en in cycle n.
- Waveform (stage 2): registered from the stage-1 phase. out_wave and out_valid update at the end of cycle n+1, so out_valid is high in cycle n+2 for one cycle. Latency from sample_en to out_valid is 2 clocks.
- out_wave holds between ticks. wave_sel is sampled at stage 2.
- Waveform definitions, with p = phase[31:16]:
  - saw: out = p ^ 0x8000.
  - square: phase[31] = 0 gives 0x7FFF, phase[31] = 1 gives 0x8001 (symmetric ±32767).
  - triangle: u = phase[31] ? ~phase[30:15] : phase[30:15]; out = u ^ 0x8000.
  - silence: out = 0x0000; out_valid still pulses.
- sample_en every cycle: full throughput with one output per clock, no stalls.
- adder_ld with no sample_en: only the registers update; phase is unchanged.

Test Plan:
1. Reset: assert rst for 3 clocks mid-run, with sample_en pulsed in the clock before rst -> out_wave = 0, out_valid = 0, wrap = 0, phase = 0, and no out_valid pulse after reset release.
2. Saw: ld 0x40000000, glide off, wave_sel = 0, sample_en every 4 clocks -> phase sequence 0x40000000, 0x80000000, 0xC0000000, 0x00000000; out_wave 0xC000, 0x0000, 0x4000, 0x8000; wrap pulses only on the 4th tick; out_valid exactly 2 clocks after each sample_en.
3. Square/triangle: same stimulus -> square 0x7FFF, 0x8001, 0x8001, 0x7FFF; triangle 0x0000, 0x7FFF, 0xFFFF, 0x8000; silence -> 0x0000 with out_valid still pulsing.
4. Glide: cur = 0, ld 0x00001000, glide_en = 1, rate = 4 -> cur_inc 0x100, then 0x1F0, monotonic, reaching exactly 0x1000 and never exceeding it. Then ld 0 -> monotonic descent to 0. Rate = 15 with diff 5 -> steps of 1.
5. Coincidence: adder_ld with sample_en while cur = 0x10 and new = 0x20, glide off -> that tick adds 0x10, the next tick adds 0x20. hard_sync with sample_en at phase 0x12345678 -> phase 0, wrap pulse.
6. Throughput: sample_en held high for 8 clocks with inc 0x20000000 -> 8 consecutive out_valid cycles with saw stepping +0x2000; wrap on cycle 8.

Source files
------------

// File: rtl/dds_phase_osc.sv
// DDS oscillator: portamento-slewed phase increment, 32-bit phase accumulator
// and a registered saw/square/triangle renderer with a wrap pulse.
module dds_phase_osc #(
  parameter int ACC_W = 32,
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_en,
  input  logic [ACC_W-1:0] adder_in,
  input  logic             adder_ld,
  input  logic             glide_en,
  input  logic [3:0]       glide_rate,
  input  logic [1:0]       wave_sel,
  input  logic             hard_sync,
  output logic [OUT_W-1:0] out_wave,
  output logic             out_valid,
  output logic             wrap
);

  localparam logic [OUT_W-1:0] SIGN_FLIP = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [OUT_W-1:0] SQ_HI     = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] SQ_LO     = {1'b1, {(OUT_W-2){1'b0}}, 1'b1};
  localparam logic [ACC_W-1:0] ONE       = {{(ACC_W-1){1'b0}}, 1'b1};

  logic [ACC_W-1:0] target_inc_q, target_inc_d;
  logic [ACC_W-1:0] cur_inc_q, cur_inc_d;
  logic [ACC_W-1:0] phase_q, phase_d;
  logic             wrap_q, wrap_d;
  logic             s1_valid_q;
  logic [OUT_W-1:0] out_wave_q, out_wave_d;
  logic             out_valid_q;

  logic             glide_up;
  logic [ACC_W-1:0] glide_diff;
  logic [ACC_W-1:0] glide_shr;
  logic [ACC_W-1:0] glide_step;
  logic [ACC_W:0]   phase_sum;
  logic [OUT_W-1:0] tri_u;

  // Step is never larger than the remaining distance, so no overshoot.
  always_comb begin
    glide_up   = cur_inc_q < target_inc_q;
    glide_diff = glide_up ? (target_inc_q - cur_inc_q) : (cur_inc_q - target_inc_q);
    glide_shr  = glide_diff >> glide_rate;
    glide_step = (glide_shr == '0) ? ONE : glide_shr;
  end

  always_comb begin
    target_inc_d = target_inc_q;
    cur_inc_d    = cur_inc_q;
    if (adder_ld) begin
      target_inc_d = adder_in;
    end
    if (!glide_en) begin
      cur_inc_d = adder_ld ? adder_in : target_inc_q;
    end else if (sample_en && (cur_inc_q != target_inc_q)) begin
      cur_inc_d = glide_up ? (cur_inc_q + glide_step) : (cur_inc_q - glide_step);
    end
  end

  // Stage 1 uses the increment as it stood before this edge's update.
  always_comb begin
    phase_sum = {1'b0, phase_q} + {1'b0, cur_inc_q};
    phase_d   = phase_q;
    wrap_d    = 1'b0;
    if (sample_en) begin
      if (hard_sync) begin
        phase_d = '0;
        wrap_d  = 1'b1;
      end else begin
        phase_d = phase_sum[ACC_W-1:0];
        wrap_d  = phase_sum[ACC_W];
      end
    end
  end

  always_comb begin
    tri_u      = phase_q[ACC_W-1] ? ~phase_q[ACC_W-2 -: OUT_W] : phase_q[ACC_W-2 -: OUT_W];
    out_wave_d = out_wave_q;
    if (s1_valid_q) begin
      case (wave_sel)
        2'd0:    out_wave_d = phase_q[ACC_W-1 -: OUT_W] ^ SIGN_FLIP;
        2'd1:    out_wave_d = phase_q[ACC_W-1] ? SQ_LO : SQ_HI;
        2'd2:    out_wave_d = tri_u ^ SIGN_FLIP;
        default: out_wave_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      target_inc_q <= '0;
      cur_inc_q    <= '0;
      phase_q      <= '0;
      wrap_q       <= 1'b0;
      s1_valid_q   <= 1'b0;
      out_wave_q   <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      target_inc_q <= target_inc_d;
      cur_inc_q    <= cur_inc_d;
      phase_q      <= phase_d;
      wrap_q       <= wrap_d;
      s1_valid_q   <= sample_en;
      out_wave_q   <= out_wave_d;
      out_valid_q  <= s1_valid_q;
    end
  end

  assign out_wave  = out_wave_q;
  assign out_valid = out_valid_q;
  assign wrap      = wrap_q;

endmodule
